// File: rtl/rat_io_pkg.sv
// Port map and shared types for the RAT MCU wrapper I/O space.
// Holds the legacy peripheral port IDs, the interrupt controller IDs and its FSM states.
package rat_io_pkg;

  localparam logic [7:0] PORT_SWITCHES    = 8'h20;
  localparam logic [7:0] PORT_LEDS        = 8'h40;
  localparam logic [7:0] PORT_KEYBOARD    = 8'h44;
  localparam logic [7:0] PORT_SSEG0       = 8'h81;
  localparam logic [7:0] PORT_SSEG1       = 8'h82;

  localparam logic [7:0] PORT_INTC_MASK   = 8'h60;
  localparam logic [7:0] PORT_INTC_ACK    = 8'h61;
  localparam logic [7:0] PORT_INTC_STATUS = 8'h62;
  localparam logic [7:0] PORT_INTC_SRCID  = 8'h63;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_ACK = 2'd2
  } intc_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rat_intr_ctrl_if.sv
// RAT MCU port bus as seen by an I/O peripheral: output writes plus the input-mux read path.
// The MCU (or wrapper) is the master; peripherals decode PORT_ID as slaves.
interface rat_intr_ctrl_if;

  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_DATA;
  logic       IN_HIT;

  modport master (
    output PORT_ID, OUT_PORT, IO_STRB,
    input  IN_DATA, IN_HIT
  );

  modport slave (
    input  PORT_ID, OUT_PORT, IO_STRB,
    output IN_DATA, IN_HIT
  );

endinterface

// File: rtl/irq_edge_capture.sv
// Per-bit rising-edge detector feeding a sticky pending register.
// A new edge and a software clear on the same bit in the same cycle leave the bit set.
module irq_edge_capture #(
  parameter int N_SRC = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] irq_i,
  input  logic [N_SRC-1:0] clr_i,
  output logic [N_SRC-1:0] pending_o
);

  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic [N_SRC-1:0] rise;

  assign rise      = irq_i & ~prev_q;
  assign pending_d = (pending_q & ~clr_i) | rise;
  assign pending_o = pending_q;

  // prev_q tracks the input even in reset, so a level held across release is not an edge.
  // NOTE: non-blocking assignments for every flop, so all registers see pre-edge values.
  always_ff @(posedge clk_i) begin
    prev_q <= irq_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/rat_intr_ctrl.sv
// Shares the RAT MCU's single INTR line among N_SRC edge-triggered sources.
// Pending/mask/ack registers on the port bus; INTR is a fixed-width pulse, then waits for an ACK.
module rat_intr_ctrl
  import rat_io_pkg::*;
#(
  parameter int         N_SRC       = 4,
  parameter int         HOLD_CYCLES = 4,
  parameter int         ACK_TIMEOUT = 1024,
  parameter logic [7:0] MASK_ID     = PORT_INTC_MASK,
  parameter logic [7:0] ACK_ID      = PORT_INTC_ACK,
  parameter logic [7:0] STATUS_ID   = PORT_INTC_STATUS,
  parameter logic [7:0] SRCID_ID    = PORT_INTC_SRCID
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [N_SRC-1:0]   IRQ_IN,
  rat_intr_ctrl_if.slave     bus,
  output logic               INTR,
  output logic [N_SRC-1:0]   PENDING
);

  localparam int                CNT_W     = $clog2(max_int(HOLD_CYCLES, ACK_TIMEOUT));
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

  logic                 wr_mask;
  logic                 wr_ack;
  logic [N_SRC-1:0]     ack_clr;
  logic [N_SRC-1:0]     mask_q;
  logic [N_SRC-1:0]     pending;
  logic [N_SRC-1:0]     active;
  logic [7:0]           srcid;

  intc_state_t          state_q;
  intc_state_t          state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;

  // Writes are plain register loads, so a strobe held for two cycles repeats harmlessly.
  assign wr_mask = bus.IO_STRB && (bus.PORT_ID == MASK_ID);
  assign wr_ack  = bus.IO_STRB && (bus.PORT_ID == ACK_ID);
  assign ack_clr = wr_ack ? bus.OUT_PORT[N_SRC-1:0] : '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mask_q <= '0;
    end else if (wr_mask) begin
      mask_q <= bus.OUT_PORT[N_SRC-1:0];
    end
  end

  irq_edge_capture #(
    .N_SRC (N_SRC)
  ) u_edge (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .irq_i     (IRQ_IN),
    .clr_i     (ack_clr),
    .pending_o (pending)
  );

  assign PENDING = pending;
  assign active  = pending & mask_q;

  // Lowest set index wins; scanning downward lets the last hit be the highest priority.
  always_comb begin
    srcid = 8'hFF;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        srcid = 8'(i);
      end
    end
  end

  always_comb begin
    bus.IN_DATA = 8'h00;
    bus.IN_HIT  = 1'b0;
    if (bus.PORT_ID == STATUS_ID) begin
      bus.IN_DATA = 8'(active);
      bus.IN_HIT  = 1'b1;
    end else if (bus.PORT_ID == SRCID_ID) begin
      bus.IN_DATA = srcid;
      bus.IN_HIT  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ASSERT ignores mask/pending changes; only WAIT_ACK listens for the ACK write.
  always_comb begin
    // NOTE: defaults first, so every path assigns and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (active != '0) begin
          state_d = ASSERT;
          cnt_d   = '0;
        end
      end
      ASSERT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_ACK: begin
        if (wr_ack || (cnt_q == ACK_LAST)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    INTR = (state_q == ASSERT);
  end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Directed plus randomized bench for rat_intr_ctrl against a time-based reference model.
module tb_rat_intr_ctrl;

  localparam int         N_SRC     = 4;
  localparam int         HOLD      = 4;
  localparam int         TMO       = 1024;
  localparam logic [7:0] MASK_ID   = 8'h60;
  localparam logic [7:0] ACK_ID    = 8'h61;
  localparam logic [7:0] STATUS_ID = 8'h62;
  localparam logic [7:0] SRCID_ID  = 8'h63;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [N_SRC-1:0] IRQ_IN;
  logic             INTR;
  logic [N_SRC-1:0] PENDING;

  rat_intr_ctrl_if bus ();

  rat_intr_ctrl #(
    .N_SRC       (N_SRC),
    .HOLD_CYCLES (HOLD),
    .ACK_TIMEOUT (TMO),
    .MASK_ID     (MASK_ID),
    .ACK_ID      (ACK_ID),
    .STATUS_ID   (STATUS_ID),
    .SRCID_ID    (SRCID_ID)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .IRQ_IN  (IRQ_IN),
    .bus     (bus),
    .INTR    (INTR),
    .PENDING (PENDING)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: registers as sets of bits, INTR as a time window.
  // A pulse started at interval m_t0 is high for HOLD intervals, then waits until an
  // ACK write or TMO waiting intervals have elapsed, then one idle interval decides again.
  int         cyc = 0;
  logic [3:0] m_prev = '0;
  logic [3:0] m_pend = '0;
  logic [3:0] m_mask = '0;
  bit         m_busy = 1'b0;
  int         m_t0   = 0;
  logic [3:0] mdl_rise;
  logic [3:0] mdl_clr;
  logic       mdl_ack;
  logic       mdl_mask_wr;

  always @(posedge CLK) begin
    mdl_ack     = bus.IO_STRB && (bus.PORT_ID == ACK_ID);
    mdl_mask_wr = bus.IO_STRB && (bus.PORT_ID == MASK_ID);
    mdl_rise    = IRQ_IN & ~m_prev;
    mdl_clr     = mdl_ack ? bus.OUT_PORT[3:0] : 4'h0;
    cyc    <= cyc + 1;
    m_prev <= IRQ_IN;
    if (RESET) begin
      m_pend <= '0;
      m_mask <= '0;
      m_busy <= 1'b0;
    end else begin
      if (mdl_mask_wr) m_mask <= bus.OUT_PORT[3:0];
      m_pend <= (m_pend & ~mdl_clr) | mdl_rise;
      if (!m_busy) begin
        if ((m_pend & m_mask) != 4'h0) begin
          m_busy <= 1'b1;
          m_t0   <= cyc + 1;
        end
      end else if (cyc >= m_t0 + HOLD) begin
        if (mdl_ack || (cyc == m_t0 + HOLD + TMO - 1)) m_busy <= 1'b0;
      end
    end
  end

  function automatic logic exp_intr();
    return m_busy && (cyc < m_t0 + HOLD);
  endfunction

  function automatic logic [7:0] exp_rd(input logic [7:0] pid);
    logic [3:0] act;
    act = m_pend & m_mask;
    if (pid == STATUS_ID) return {4'h0, act};
    if (pid == SRCID_ID) begin
      for (int i = 0; i < 4; i++) begin
        if (act[i]) return 8'(i);
      end
      return 8'hFF;
    end
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/intr"}, 32'(INTR), 32'(exp_intr()));
    check({tag, "/pend"}, 32'(PENDING), 32'(m_pend));
    check({tag, "/rd"}, 32'(bus.IN_DATA), 32'(exp_rd(bus.PORT_ID)));
    check({tag, "/hit"}, 32'(bus.IN_HIT),
          32'((bus.PORT_ID == STATUS_ID) || (bus.PORT_ID == SRCID_ID)));
  endtask

  task automatic step(input string tag, input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
      check_all(tag);
    end
  endtask

  task automatic io_write(input logic [7:0] id, input logic [7:0] data, input string tag);
    bus.PORT_ID  = id;
    bus.OUT_PORT = data;
    bus.IO_STRB  = 1'b1;
    step(tag, 2);
    bus.IO_STRB  = 1'b0;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
  endtask

  task automatic read_chk(input logic [7:0] id, input logic [7:0] exp, input string tag);
    bus.PORT_ID = id;
    #1;
    check(tag, 32'(bus.IN_DATA), 32'(exp));
    check({tag, "/hit"}, 32'(bus.IN_HIT), 32'(1));
  endtask

  int         rise1, rise2, nrise;
  logic       last_intr;
  logic [7:0] ids [6];

  initial begin
    RESET        = 1'b1;
    IRQ_IN       = '0;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.IO_STRB  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    check_all("reset");
    check("rst_pend", 32'(PENDING), 32'(0));
    check("rst_intr", 32'(INTR), 32'(0));
    read_chk(SRCID_ID, 8'hFF, "rst_srcid");
    bus.PORT_ID = 8'h00;

    // 1: single source, full pulse, then ACK
    io_write(MASK_ID, 8'h01, "t1_mask");
    IRQ_IN = 4'b0001;
    step("t1_edge");
    IRQ_IN = 4'b0000;
    check("t1_pend", 32'(PENDING), 32'(1));
    check("t1_lat", 32'(INTR), 32'(0));
    for (int i = 0; i < HOLD; i++) begin
      step("t1_pulse");
      check("t1_intr_hi", 32'(INTR), 32'(1));
    end
    step("t1_end");
    check("t1_intr_lo", 32'(INTR), 32'(0));
    read_chk(STATUS_ID, 8'h01, "t1_status");
    read_chk(SRCID_ID, 8'h00, "t1_srcid");
    bus.PORT_ID = 8'h00;
    io_write(ACK_ID, 8'h01, "t1_ack");
    check("t1_pend_clr", 32'(PENDING), 32'(0));
    for (int i = 0; i < 10; i++) begin
      step("t1_quiet");
      check("t1_no_intr", 32'(INTR), 32'(0));
    end

    // 2: two simultaneous sources, priority and re-raise after ACK
    io_write(MASK_ID, 8'h0F, "t2_mask");
    IRQ_IN = 4'b1010;
    step("t2_edge");
    IRQ_IN = 4'b0000;
    read_chk(SRCID_ID, 8'h01, "t2_srcid1");
    bus.PORT_ID = 8'h00;
    step("t2_pulse", 6);
    io_write(ACK_ID, 8'h02, "t2_ack1");
    check("t2_reraise", 32'(INTR), 32'(1));
    read_chk(SRCID_ID, 8'h03, "t2_srcid3");
    bus.PORT_ID = 8'h00;
    step("t2_pulse2", 4);
    io_write(ACK_ID, 8'h08, "t2_ack2");
    for (int i = 0; i < 10; i++) begin
      step("t2_quiet");
      check("t2_no_intr", 32'(INTR), 32'(0));
    end

    // 3: masked source latches, unmasking triggers
    io_write(MASK_ID, 8'h00, "t3_mask0");
    IRQ_IN = 4'b0100;
    step("t3_edge");
    IRQ_IN = 4'b0000;
    step("t3_wait", 3);
    check("t3_pend", 32'(PENDING), 32'(4'b0100));
    check("t3_no_intr", 32'(INTR), 32'(0));
    read_chk(STATUS_ID, 8'h00, "t3_status");
    read_chk(SRCID_ID, 8'hFF, "t3_srcid");
    bus.PORT_ID = 8'h00;
    io_write(MASK_ID, 8'h04, "t3_unmask");
    check("t3_intr", 32'(INTR), 32'(1));
    step("t3_pulse", 5);
    io_write(ACK_ID, 8'h04, "t3_ack");
    step("t3_idle", 4);

    // 4: no ACK, pulses repeat on timeout
    io_write(MASK_ID, 8'h01, "t4_mask");
    IRQ_IN = 4'b0001;
    step("t4_edge");
    IRQ_IN = 4'b0000;
    nrise = 0; rise1 = 0; rise2 = 0; last_intr = INTR;
    for (int i = 0; i < 2100; i++) begin
      step("t4_run");
      if (INTR && !last_intr) begin
        nrise++;
        if (nrise == 1) rise1 = i;
        if (nrise == 2) rise2 = i;
      end
      last_intr = INTR;
    end
    check("t4_period", 32'(rise2 - rise1), 32'(HOLD + TMO + 1));
    io_write(ACK_ID, 8'h01, "t4_ack");
    step("t4_idle", 4);

    // 5: set beats clear; repeated ACK strobe is idempotent
    IRQ_IN = 4'b0001;
    step("t5_edge");
    IRQ_IN = 4'b0000;
    step("t5_settle");
    bus.PORT_ID = ACK_ID; bus.OUT_PORT = 8'h01; bus.IO_STRB = 1'b1;
    step("t5_clr");
    check("t5_clr", 32'(PENDING[0]), 32'(0));
    IRQ_IN = 4'b0001;
    step("t5_collide");
    bus.IO_STRB = 1'b0; bus.PORT_ID = 8'h00; bus.OUT_PORT = 8'h00;
    check("t5_set_wins", 32'(PENDING[0]), 32'(1));
    IRQ_IN = 4'b0111;
    step("t5_more");
    IRQ_IN = 4'b0000;
    step("t5_more2");
    check("t5_pend3", 32'(PENDING), 32'(4'b0111));
    io_write(ACK_ID, 8'h02, "t5_idem");
    check("t5_idem", 32'(PENDING), 32'(4'b0101));
    step("t5_tail", 8);

    // 6: level across reset release; reset during ASSERT
    IRQ_IN = 4'b0001;
    RESET  = 1'b1;
    step("t6_rst", 2);
    RESET  = 1'b0;
    step("t6_rel", 3);
    check("t6_level", 32'(PENDING), 32'(0));
    io_write(MASK_ID, 8'h01, "t6_mask");
    IRQ_IN = 4'b0000;
    step("t6_low");
    IRQ_IN = 4'b0001;
    step("t6_edge");
    step("t6_assert");
    check("t6_pre", 32'(INTR), 32'(1));
    RESET = 1'b1;
    step("t6_mid_rst");
    RESET = 1'b0;
    check("t6_intr_drop", 32'(INTR), 32'(0));
    check("t6_pend_drop", 32'(PENDING), 32'(0));
    IRQ_IN = 4'b0000;
    step("t6_low2");
    IRQ_IN = 4'b0001;
    step("t6_edge2");
    check("t6_pend_new", 32'(PENDING), 32'(1));
    read_chk(STATUS_ID, 8'h00, "t6_mask_rst");
    step("t6_quiet", 3);
    check("t6_no_intr", 32'(INTR), 32'(0));

    // Randomized traffic against the model
    ids = '{MASK_ID, ACK_ID, STATUS_ID, SRCID_ID, 8'h20, 8'h44};
    for (int it = 0; it < 1500; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          IRQ_IN = 4'($urandom);
          step("rnd_irq");
        end
        5: io_write(MASK_ID, 8'($urandom), "rnd_mask");
        6: io_write(ACK_ID, 8'($urandom), "rnd_ack");
        7: begin
          bus.PORT_ID = ids[$urandom_range(0, 5)];
          step("rnd_read");
        end
        8: begin
          bus.PORT_ID  = ids[$urandom_range(0, 5)];
          bus.OUT_PORT = 8'($urandom);
          bus.IO_STRB  = 1'b1;
          step("rnd_strb");
          bus.IO_STRB  = 1'b0;
        end
        default: begin
          if ($urandom_range(0, 19) == 0) begin
            RESET = 1'b1;
            step("rnd_rst");
            RESET = 1'b0;
          end else begin
            step("rnd_idle", 3);
          end
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
